instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 16-bit instruction datapath. It fetches instruction words from instruction memory over a request/valid handshake and latches each word onto `order`. It then sequences the execute-stage decoder through an execute window and a write-back strobe, and advances the PC. It sits between instruction memory and the execute decoder / register-file write port.

---
 rtl/instr_sequencer.sv | 102 ++++++++++
 tb/tb_instr_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 16-bit instruction datapath.
// States: IDLE, FETCH, WAIT, DECODE, EXEC, WB, ADV, HALT. All outputs are registered Moore outputs.
module instr_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] PC_LAST     = 8'hFF,
    parameter int                EXEC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       order,
    output logic              exec_en,
    output logic              wb_en,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        WB     = 3'd5,
        ADV    = 3'd6,
        HALT   = 3'd7
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] exec_cnt;
    logic [3:0] opcode;
    logic       op_alu;
    logic       op_legal;

    assign mem_addr = pc;
    assign opcode   = order[15:12];
    assign op_alu   = (opcode == 4'b0111) || (opcode == 4'b1000);
    assign op_legal = op_alu || (opcode == 4'b0000) || (opcode == 4'b1111);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH:  state_nxt = WAIT;
            WAIT:   if (mem_valid) state_nxt = DECODE;
            DECODE: begin
                if (op_alu)                  state_nxt = EXEC;
                else if (opcode == 4'b1111)  state_nxt = HALT;
                else                         state_nxt = ADV;
            end
            EXEC:   if (exec_cnt == 4'd0) state_nxt = WB;
            WB:     state_nxt = ADV;
            ADV:    state_nxt = (pc == PC_LAST) ? HALT : FETCH;
            HALT:   if (start) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            order    <= '0;
            illegal  <= 1'b0;
            exec_cnt <= '0;
            mem_rd   <= 1'b0;
            exec_en  <= 1'b0;
            wb_en    <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_rd  <= (state_nxt == FETCH);
            exec_en <= (state_nxt == EXEC);
            wb_en   <= (state_nxt == WB);
            busy    <= (state_nxt != IDLE) && (state_nxt != HALT);
            halted  <= (state_nxt == HALT);
            case (state)
                WAIT:   if (mem_valid) order <= mem_rdata;
                DECODE: begin
                    exec_cnt <= CNT_LOAD;
                    if (!op_legal) illegal <= 1'b1;
                end
                EXEC:   if (exec_cnt != 4'd0) exec_cnt <= exec_cnt - 4'd1;
                ADV:    if (pc != PC_LAST) pc <= pc + 1'b1;
                HALT:   if (start) pc <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: default instance plus a PC_LAST=2 instance.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic [15:0] order;
    logic        exec_en, wb_en, busy, halted, illegal;
    logic [7:0]  pc;

    logic        start5 = 1'b0;
    logic [7:0]  mem_addr5;
    logic        mem_rd5;
    logic [15:0] mem_rdata5 = '0;
    logic        mem_valid5 = 1'b0;
    logic [15:0] order5;
    logic        exec_en5, wb_en5, busy5, halted5, illegal5;
    logic [7:0]  pc5;

    logic [15:0] mem [256];
    int          dly = 1;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    instr_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .order(order), .exec_en(exec_en),
        .wb_en(wb_en), .busy(busy), .halted(halted), .illegal(illegal), .pc(pc)
    );

    instr_sequencer #(.PC_LAST(8'h02)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .mem_addr(mem_addr5), .mem_rd(mem_rd5),
        .mem_rdata(mem_rdata5), .mem_valid(mem_valid5), .order(order5), .exec_en(exec_en5),
        .wb_en(wb_en5), .busy(busy5), .halted(halted5), .illegal(illegal5), .pc(pc5)
    );

    // Memory models: answer a read request `dly` cycles later with a one-cycle valid.
    initial begin
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (mem_rd) begin
                a = mem_addr;
                repeat (dly) @(negedge clk);
                mem_rdata = mem[a];
                mem_valid = 1'b1;
                @(negedge clk);
                mem_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd5) begin
                @(negedge clk);
                mem_rdata5 = 16'h7000;
                mem_valid5 = 1'b1;
                @(negedge clk);
                mem_valid5 = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (8) tick();
        rst = 1'b0;
    endtask

    task automatic run_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // {mem_rd, exec_en, wb_en} per cycle starting at the FETCH cycle
    logic [2:0] exp_t1 [8]  = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b010, 3'b001, 3'b000, 3'b100};
    logic [2:0] exp_t3 [12] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b010, 3'b010, 3'b001, 3'b000, 3'b100};

    initial begin
        int n;
        int wbc;
        clear_mem();
        tick();
        do_reset();

        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_order", order, 16'h0000);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_illegal", illegal, 1'b0);

        // ALU instruction timing
        mem[0] = 16'h7A40;
        run_start();
        chk("t1_addr0", mem_addr, 8'h00);
        chk("t1_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) chk("t1_order", order, 16'h7A40);
            chk($sformatf("t1_trace%0d", i), {mem_rd, exec_en, wb_en}, exp_t1[i]);
            if (i == 7) chk("t1_next_addr", mem_addr, 8'h01);
            if (i < 7) tick();
        end

        // NOP then HLT, restart
        do_reset();
        clear_mem();
        mem[1] = 16'hF000;
        run_start();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_nop%0d", i), {exec_en, wb_en}, 2'b00);
            tick();
        end
        chk("t2_fetch1", mem_rd, 1'b1);
        chk("t2_addr1", mem_addr, 8'h01);
        repeat (3) tick();
        chk("t2_halted", halted, 1'b1);
        chk("t2_pc", pc, 8'h01);
        chk("t2_busy", busy, 1'b0);
        run_start();
        chk("t2_refetch", mem_rd, 1'b1);
        chk("t2_refetch_addr", mem_addr, 8'h00);

        // delayed memory response
        do_reset();
        clear_mem();
        mem[0] = 16'h8123;
        dly = 5;
        run_start();
        for (int i = 0; i < 12; i++) begin
            if (i == 5) chk("t3_order_wait", order, 16'h0000);
            if (i == 6) chk("t3_order", order, 16'h8123);
            chk($sformatf("t3_trace%0d", i), {mem_rd, exec_en, wb_en}, exp_t3[i]);
            if (i < 11) tick();
        end
        dly = 1;

        // illegal opcode, sticky across halt/restart
        do_reset();
        clear_mem();
        mem[0] = 16'h3000;
        mem[1] = 16'hF000;
        run_start();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_noexec%0d", i), exec_en, 1'b0);
            tick();
        end
        chk("t4_illegal", illegal, 1'b1);
        chk("t4_pc", pc, 8'h01);
        repeat (3) tick();
        chk("t4_halted", halted, 1'b1);
        run_start();
        chk("t4_restart_addr", mem_addr, 8'h00);
        chk("t4_sticky", illegal, 1'b1);
        do_reset();
        chk("t4_cleared", illegal, 1'b0);

        // PC_LAST = 2 instance
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        n = 0;
        wbc = 0;
        while (!halted5 && n < 60) begin
            if (wb_en5) wbc++;
            tick();
            n++;
        end
        chk("t5_timeout", (n < 60), 1'b1);
        chk("t5_wb_count", wbc, 3);
        chk("t5_pc", pc5, 8'h02);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        chk("t5_restart_rd", mem_rd5, 1'b1);
        chk("t5_restart_addr", mem_addr5, 8'h00);

        // reset during EXEC and during WAIT
        do_reset();
        clear_mem();
        mem[0] = 16'h7A40;
        run_start();
        repeat (3) tick();
        chk("t6_in_exec", exec_en, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6a_busy", busy, 1'b0);
        chk("t6a_pc", pc, 8'h00);
        chk("t6a_order", order, 16'h0000);
        chk("t6a_strobes", {mem_rd, exec_en, wb_en, halted}, 4'b0000);
        dly = 3;
        run_start();
        tick();
        chk("t6_in_wait", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6b_busy", busy, 1'b0);
        chk("t6b_order", order, 16'h0000);
        chk("t6b_strobes", {mem_rd, exec_en, wb_en, halted}, 4'b0000);
        repeat (4) tick();
        chk("t6_late_valid_order", order, 16'h0000);
        chk("t6_late_valid_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
